// File: rtl/collector_drain_pkg.sv
// rtl/collector_drain_pkg.sv - shared constants and helpers for the collector drain stage
package collector_drain_pkg;

  localparam int DEF_DATA_WIDTH        = 64;
  localparam int DEF_FIFO_DEPTH        = 4;
  localparam int DEF_RESULTS_PER_FRAME = 16;

  localparam int FRAME_CNT_W = 16;
  localparam int WORD_CNT_W  = 32;

  // Index width for a power-of-two buffer of the given depth
  function automatic int log2_ceil(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

  // Word-in-frame index width; a one-word frame still needs a 1-bit index
  function automatic int idx_width(input int words_per_frame);
    return (words_per_frame > 1) ? $clog2(words_per_frame) : 1;
  endfunction

  localparam int PTR_W = log2_ceil(DEF_FIFO_DEPTH);

endpackage

// File: rtl/collector_drain_if.sv
// rtl/collector_drain_if.sv - collector FIFO read port plus AXI-Stream output bundle
interface collector_drain_if
  import collector_drain_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                  collector_ofifo_rdy;
  logic                  collector_ofifo_ren;
  logic [DATA_WIDTH-1:0] collector_ofifo_rdata;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;

  // Environment side: owns the collector FIFO and the downstream sink
  modport master (
    output collector_ofifo_rdy,
    input  collector_ofifo_ren,
    output collector_ofifo_rdata,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    output m_axis_tready,
    input  m_axis_tlast
  );

  // Drain side: reads the collector and drives the stream
  modport slave (
    input  collector_ofifo_rdy,
    output collector_ofifo_ren,
    input  collector_ofifo_rdata,
    output m_axis_tdata,
    output m_axis_tvalid,
    input  m_axis_tready,
    output m_axis_tlast
  );

endinterface

// File: rtl/drain_skid_fifo.sv
// rtl/drain_skid_fifo.sv - small synchronous FIFO absorbing the collector read latency
module drain_skid_fifo
  import collector_drain_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_FIFO_DEPTH,
  localparam int PW        = log2_ceil(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [PW:0]           o_occupancy
);

  localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]           r_wr_ptr;
  logic [PW:0]           r_rd_ptr;
  logic                  w_wr_en;
  logic                  w_rd_en;

  // Extra wrap bit distinguishes full from empty when the index bits match
  assign o_empty     = (r_wr_ptr == r_rd_ptr);
  assign o_full      = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                       (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign o_occupancy = r_wr_ptr - r_rd_ptr;
  assign o_rdata     = r_mem[r_rd_ptr[PW-1:0]];

  // A full buffer still accepts a write when the head leaves in the same cycle
  assign w_rd_en = i_pop & ~o_empty;
  assign w_wr_en = i_push & (~o_full | w_rd_en);

  // Storage and write pointer; entries are cleared so tdata reads 0 out of reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[r_wr_ptr[PW-1:0]] <= i_wdata;
      r_wr_ptr                <= r_wr_ptr + PTR_ONE;
    end
  end

  // Read pointer advances on each pop of a non-empty buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
    end else if (w_rd_en) begin
      r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/collector_drain.sv
// rtl/collector_drain.sv - credit-managed collector drain re-emitting results as a framed stream
module collector_drain
  import collector_drain_pkg::*;
#(
  parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH        = DEF_FIFO_DEPTH,
  parameter int RESULTS_PER_FRAME = DEF_RESULTS_PER_FRAME
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   drain_en,
  collector_drain_if.slave       bus,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [WORD_CNT_W-1:0]  word_count,
  output logic                   overflow_err
);

  localparam int BUF_PTR_W = log2_ceil(FIFO_DEPTH);
  localparam int USED_W    = BUF_PTR_W + 2;
  localparam int IDX_W     = idx_width(RESULTS_PER_FRAME);

  localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(RESULTS_PER_FRAME - 1);
  localparam logic [IDX_W-1:0]       IDX_ONE   = IDX_W'(1);
  localparam logic [USED_W-1:0]      CREDITS   = USED_W'(FIFO_DEPTH);
  localparam logic [FRAME_CNT_W-1:0] FRAME_ONE = FRAME_CNT_W'(1);
  localparam logic [WORD_CNT_W-1:0]  WORD_ONE  = WORD_CNT_W'(1);

  logic                   r_inflight;
  logic [IDX_W-1:0]       r_word_idx;
  logic [FRAME_CNT_W-1:0] r_frame_count;
  logic [WORD_CNT_W-1:0]  r_word_count;
  logic                   r_overflow;

  logic [BUF_PTR_W:0]     w_occ;
  logic [USED_W-1:0]      w_used;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_ren;
  logic                   w_tvalid;
  logic                   w_tlast;
  logic                   w_pop;
  logic [DATA_WIDTH-1:0]  w_head;

  // A read is only issued when the buffer has room for it after the in-flight word lands;
  // reset gates the strobe so nothing is requested while state is being cleared
  assign w_used = USED_W'(w_occ) + USED_W'(r_inflight);
  assign w_ren  = reset & drain_en & bus.collector_ofifo_rdy & (w_used < CREDITS);

  assign w_tvalid = ~w_empty;
  assign w_tlast  = w_tvalid & (r_word_idx == LAST_IDX);
  assign w_pop    = w_tvalid & bus.m_axis_tready;

  assign bus.collector_ofifo_ren = w_ren;
  assign bus.m_axis_tdata        = w_head;
  assign bus.m_axis_tvalid       = w_tvalid;
  assign bus.m_axis_tlast        = w_tlast;

  assign frame_count  = r_frame_count;
  assign word_count   = r_word_count;
  assign overflow_err = r_overflow;

  drain_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_buf (
    .clk         (clk),
    .reset       (reset),
    .i_push      (r_inflight),
    .i_wdata     (bus.collector_ofifo_rdata),
    .i_pop       (w_pop),
    .o_rdata     (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_occupancy (w_occ)
  );

  // Read data arrives one cycle after the strobe; remember that a word is on its way
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_ren;
    end
  end

  // A landing word with no room and no pop is dropped and flagged until reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (r_inflight && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  // Word-in-frame index and completed-frame count, both advanced by accepted words
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word_idx    <= '0;
      r_frame_count <= '0;
    end else if (w_pop) begin
      if (r_word_idx == LAST_IDX) begin
        r_word_idx    <= '0;
        r_frame_count <= r_frame_count + FRAME_ONE;
      end else begin
        r_word_idx <= r_word_idx + IDX_ONE;
      end
    end
  end

  // Accepted-word count saturates rather than wrapping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word_count <= '0;
    end else if (w_pop && (r_word_count != '1)) begin
      r_word_count <= r_word_count + WORD_ONE;
    end
  end

endmodule

// File: tb/tb_collector_drain.sv
// tb/tb_collector_drain.sv - scoreboard bench for collector_drain
module tb_collector_drain;
  import collector_drain_pkg::*;

  localparam int DW = 64;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic drain_en = 1'b0;
  logic drain_en1 = 1'b0;
  logic [FRAME_CNT_W-1:0] frame_count, frame_count1;
  logic [WORD_CNT_W-1:0]  word_count, word_count1;
  logic overflow_err, overflow_err1;

  collector_drain_if #(.DATA_WIDTH(DW)) bus0 ();
  collector_drain_if #(.DATA_WIDTH(DW)) bus1 ();

  collector_drain #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .RESULTS_PER_FRAME(16)) dut0 (
    .clk(clk), .reset(reset), .drain_en(drain_en), .bus(bus0),
    .frame_count(frame_count), .word_count(word_count), .overflow_err(overflow_err));

  collector_drain #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .RESULTS_PER_FRAME(1)) dut1 (
    .clk(clk), .reset(reset), .drain_en(drain_en1), .bus(bus1),
    .frame_count(frame_count1), .word_count(word_count1), .overflow_err(overflow_err1));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  exp_t exp_q[$];
  logic [DW-1:0] exp1_q[$];
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] src1_q[$];
  int exp_idx = 0;
  bit ren_seen = 0, ren1_seen = 0;
  int ren_count = 0, out_count = 0, out1_count = 0;
  int first_ren_cyc = -1;
  bit t1_active = 0, rdy_rand_en = 0, tready_rand = 0;
  logic tready_fixed = 1'b1;
  logic [DW-1:0] first_out = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string detail);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s", name, detail);
  endtask

  always @(posedge clk) cyc++;

  // Collector FIFO model for dut0: supplies the next word the cycle after ren and queues the expectation
  always @(posedge clk) begin
    logic [DW-1:0] w;
    #1;
    if (ren_seen) begin
      if (src_q.size() == 0) begin
        fail_now("ren_without_data", "actual ren=1 required ren=0 while collector empty");
        bus0.collector_ofifo_rdata = '1;
      end else begin
        w = src_q.pop_front();
        bus0.collector_ofifo_rdata = w;
        exp_q.push_back('{data: w, last: (exp_idx == 15)});
        exp_idx = (exp_idx == 15) ? 0 : exp_idx + 1;
      end
    end else begin
      bus0.collector_ofifo_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    end
    bus0.collector_ofifo_rdy = (src_q.size() != 0) && (rdy_rand_en ? ($urandom_range(0, 1) == 1) : 1'b1);
    bus0.m_axis_tready = tready_rand ? ($urandom_range(0, 1) == 1) : tready_fixed;
  end

  // Read-strobe sampler and output monitor for dut0
  always @(negedge clk) begin
    exp_t e;
    ren_seen = bus0.collector_ofifo_ren;
    if (ren_seen) begin
      ren_count++;
      if (first_ren_cyc < 0) first_ren_cyc = cyc;
    end
    if (bus0.m_axis_tvalid && bus0.m_axis_tready) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_word", $sformatf("actual word %0h required none", bus0.m_axis_tdata));
      end else begin
        e = exp_q.pop_front();
        chk("tdata", bus0.m_axis_tdata, e.data);
        chk("tlast", 64'(bus0.m_axis_tlast), 64'(e.last));
      end
      if (t1_active) chk("t1_timing", 64'(cyc), 64'(first_ren_cyc + 2 + out_count));
      if (out_count == 0) first_out = bus0.m_axis_tdata;
      out_count++;
    end
  end

  // Collector FIFO model for the one-word-frame build
  always @(posedge clk) begin
    logic [DW-1:0] w1;
    #1;
    if (ren1_seen) begin
      if (src1_q.size() == 0) begin
        fail_now("ren1_without_data", "actual ren=1 required ren=0 while collector empty");
        bus1.collector_ofifo_rdata = '1;
      end else begin
        w1 = src1_q.pop_front();
        bus1.collector_ofifo_rdata = w1;
        exp1_q.push_back(w1);
      end
    end else begin
      bus1.collector_ofifo_rdata = 64'hBAD1_BAD1_BAD1_BAD1;
    end
    bus1.collector_ofifo_rdy = (src1_q.size() != 0);
    bus1.m_axis_tready = 1'b1;
  end

  // Read-strobe sampler and output monitor for the one-word-frame build
  always @(negedge clk) begin
    ren1_seen = bus1.collector_ofifo_ren;
    if (bus1.m_axis_tvalid && bus1.m_axis_tready) begin
      if (exp1_q.size() == 0) begin
        fail_now("unexpected_word1", $sformatf("actual word %0h required none", bus1.m_axis_tdata));
      end else begin
        chk("tdata1", bus1.m_axis_tdata, exp1_q.pop_front());
      end
      chk("tlast1", 64'(bus1.m_axis_tlast), 64'd1);
      out1_count++;
    end
  end

  task automatic reset_assert();
    reset = 1'b0;
    drain_en = 1'b0;
    drain_en1 = 1'b0;
    exp_q.delete();
    exp1_q.delete();
    exp_idx = 0;
    ren_count = 0;
    out_count = 0;
    out1_count = 0;
    first_ren_cyc = -1;
  endtask

  task automatic reset_release();
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_assert();
    repeat (2) @(negedge clk);
    reset_release();
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (!(src_q.size() == 0 && exp_q.size() == 0 && !bus0.m_axis_tvalid) && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (n >= budget) fail_now({name, "_timeout"}, $sformatf("actual busy after %0d cycles required idle", budget));
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: actual still running required finished");
    $fatal(1);
  end

  initial begin
    int n;
    bit seen;
    bit stable;
    logic [DW-1:0] held;

    reset_assert();
    repeat (3) @(negedge clk);
    #2;
    chk("rst_ren", 64'(bus0.collector_ofifo_ren), 64'd0);
    chk("rst_tvalid", 64'(bus0.m_axis_tvalid), 64'd0);
    chk("rst_tlast", 64'(bus0.m_axis_tlast), 64'd0);
    chk("rst_tdata", bus0.m_axis_tdata, 64'd0);
    chk("rst_frame_count", 64'(frame_count), 64'd0);
    chk("rst_word_count", 64'(word_count), 64'd0);
    chk("rst_overflow", 64'(overflow_err), 64'd0);
    reset_release();

    // Test 1: 0x1..0x10 with everything ready, one frame
    do_reset();
    tready_fixed = 1'b1;
    @(posedge clk);
    #2;
    for (int i = 1; i <= 16; i++) src_q.push_back(64'(i));
    t1_active = 1;
    drain_en = 1'b1;
    wait_drain(200, "t1");
    t1_active = 0;
    chk("t1_frame_count", 64'(frame_count), 64'd1);
    chk("t1_word_count", 64'(word_count), 64'd16);
    chk("t1_out_count", 64'(out_count), 64'd16);
    chk("t1_overflow", 64'(overflow_err), 64'd0);

    // Test 2: backpressure fills exactly FIFO_DEPTH credits
    do_reset();
    tready_fixed = 1'b0;
    @(posedge clk);
    #2;
    for (int i = 0; i < 12; i++) src_q.push_back(64'h100 + 64'(i));
    drain_en = 1'b1;
    seen = 0;
    stable = 1;
    held = '0;
    repeat (10) begin
      @(negedge clk);
      #2;
      if (bus0.m_axis_tvalid) begin
        if (!seen) held = bus0.m_axis_tdata;
        else if (bus0.m_axis_tdata !== held) stable = 0;
        seen = 1;
      end
    end
    chk("t2_ren_count", 64'(ren_count), 64'd4);
    chk("t2_tvalid", 64'(bus0.m_axis_tvalid), 64'd1);
    chk("t2_tdata", bus0.m_axis_tdata, 64'h100);
    chk("t2_tdata_stable", 64'(stable), 64'd1);
    chk("t2_overflow", 64'(overflow_err), 64'd0);
    tready_fixed = 1'b1;
    wait_drain(300, "t2");
    chk("t2_word_count", 64'(word_count), 64'd12);
    chk("t2_ren_total", 64'(ren_count), 64'd12);

    // Test 3: drain_en drops right after a read is issued
    do_reset();
    tready_fixed = 1'b1;
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) src_q.push_back(64'h200 + 64'(i));
    drain_en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus0.collector_ofifo_ren && n < 50);
    if (n >= 50) fail_now("t3_no_ren", "actual ren never high required one read");
    @(posedge clk);
    #2;
    drain_en = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    chk("t3_ren_count", 64'(ren_count), 64'd1);
    chk("t3_out_count", 64'(out_count), 64'd1);
    @(posedge clk);
    #2;
    drain_en = 1'b1;
    wait_drain(200, "t3");
    chk("t3_out_total", 64'(out_count), 64'd3);
    chk("t3_word_count", 64'(word_count), 64'd3);

    // Test 4: random rdy and tready over 1000 words
    do_reset();
    rdy_rand_en = 1;
    tready_rand = 1;
    @(posedge clk);
    #2;
    for (int i = 0; i < 1000; i++) src_q.push_back({32'hC0DE_0000, 32'(i)});
    drain_en = 1'b1;
    wait_drain(30000, "t4");
    rdy_rand_en = 0;
    tready_rand = 0;
    chk("t4_frame_count", 64'(frame_count), 64'd62);
    chk("t4_word_count", 64'(word_count), 64'd1000);
    chk("t4_out_count", 64'(out_count), 64'd1000);
    chk("t4_overflow", 64'(overflow_err), 64'd0);

    // Test 5: asynchronous reset with three buffered words and one in flight
    do_reset();
    tready_fixed = 1'b0;
    @(posedge clk);
    #2;
    for (int i = 0; i < 10; i++) src_q.push_back(64'h300 + 64'(i));
    drain_en = 1'b1;
    n = 0;
    while (ren_count < 4 && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (n >= 50) fail_now("t5_fill", "actual fewer than 4 reads required 4");
    @(posedge clk);
    #3;
    chk("t5_pre_tvalid", 64'(bus0.m_axis_tvalid), 64'd1);
    reset_assert();
    #1;
    chk("t5_ren", 64'(bus0.collector_ofifo_ren), 64'd0);
    chk("t5_tvalid", 64'(bus0.m_axis_tvalid), 64'd0);
    chk("t5_tlast", 64'(bus0.m_axis_tlast), 64'd0);
    chk("t5_tdata", bus0.m_axis_tdata, 64'd0);
    chk("t5_frame_count", 64'(frame_count), 64'd0);
    chk("t5_word_count", 64'(word_count), 64'd0);
    chk("t5_overflow", 64'(overflow_err), 64'd0);
    repeat (2) @(negedge clk);
    tready_fixed = 1'b1;
    drain_en = 1'b1;
    reset_release();
    wait_drain(200, "t5");
    chk("t5_out_count", 64'(out_count), 64'd6);
    chk("t5_first_out", first_out, 64'h304);
    chk("t5_word_total", 64'(word_count), 64'd6);

    // Test 6: one-word frames
    do_reset();
    @(posedge clk);
    #2;
    for (int i = 0; i < 5; i++) src1_q.push_back(64'h600 + 64'(i));
    drain_en1 = 1'b1;
    n = 0;
    while (!(src1_q.size() == 0 && exp1_q.size() == 0 && !bus1.m_axis_tvalid) && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (n >= 200) fail_now("t6_timeout", "actual busy required idle");
    chk("t6_frame_count", 64'(frame_count1), 64'd5);
    chk("t6_word_count", 64'(word_count1), 64'd5);
    chk("t6_out_count", 64'(out1_count), 64'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/collector_drain.md
Name: collector_drain

Overview:
- Downstream stage of mlp_1: empties the collector output FIFO through its rdy/ren/rdata interface.
- Absorbs the FIFO's 1-cycle read latency in a small credit-managed buffer.
- Re-emits results as an AXI-Stream with tlast framing every RESULTS_PER_FRAME words.
- Maintains frame/word counters and a sticky error flag; replaces the free-running ren loop used in simulation today.

Parameters:
- DATA_WIDTH, 64, width of collector result words and output tdata.
- FIFO_DEPTH, 4, internal buffer entries; power of two, minimum 4.
- RESULTS_PER_FRAME, 16, words per output frame; tlast marks the last one; minimum 1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset. Asserting low clears all state immediately; deassertion is synchronous to clk.
- drain_en  input  1  permits new collector reads when high.
- collector_ofifo_rdy  input  1  collector FIFO non-empty.
- collector_ofifo_ren  output  1  collector FIFO read strobe.
- collector_ofifo_rdata  input  DATA_WIDTH  read data, valid the cycle after ren.
- m_axis_tdata  output  DATA_WIDTH  result word.
- m_axis_tvalid  output  1  word available.
- m_axis_tready  input  1  downstream accept.
- m_axis_tlast  output  1  last word of frame.
- frame_count  output  16  completed frames, wraps at 2^16.
- word_count  output  32  words accepted downstream, saturates at 2^32-1.
- overflow_err  output  1  sticky: write attempted into a full buffer.

Behaviour:
- Reset (reset low): ren=0, tvalid=0, tlast=0, buffer empty, inflight=0, word index=0, frame_count=0, word_count=0, overflow_err=0.
- Reset mid-operation: an in-flight read is discarded and its data lost; this is accepted behaviour.
- Read issue is combinational: ren = drain_en & collector_ofifo_rdy & (occupancy + inflight < FIFO_DEPTH).
- inflight is ren registered, so it is 1 in the cycle after ren.
- Capture: when inflight=1, collector_ofifo_rdata is written to the buffer tail at that cycle's clock edge.
- Latency: ren in cycle t → data captured end of t+1 → tvalid high in cycle t+2.
  - Each result passes through exactly one register stage and one buffer entry.
- Throughput: with rdy=1, drain_en=1 and tready=1 sustained, one word per cycle after the 2-cycle fill.
- Output side:
  - tvalid = buffer non-empty; tdata = head entry.
  - Pop on tvalid & tready.
  - tdata and tlast stay stable while tvalid=1 and tready=0.
- Simultaneous capture and pop: occupancy unchanged, both take effect.
- Pop when empty: cannot occur, since tvalid gates it.
- Full boundary: the credit rule guarantees no write into a full buffer.
  - If such a write ever happens (e.g. rdata with no preceding ren is impossible, but guard anyway), the word is dropped and overflow_err is set.
  - overflow_err stays set until reset.
- Framing:
  - tlast = tvalid & (word index == RESULTS_PER_FRAME-1).
  - The word index increments on each accepted word.
  - On an accepted tlast word: index returns to 0 and frame_count increments, wrapping 0xFFFF→0.
  - RESULTS_PER_FRAME=1: tlast is set on every word.
- word_count increments on each accepted word and holds at 0xFFFFFFFF.
- drain_en falling: ren stops the same cycle. An already in-flight word is still captured, and buffered words still drain to the output.
- collector_ofifo_rdy dropping while inflight=1: the capture still occurs, since the read was already issued.

Decomposition:
- Shared package collector_drain_pkg:
  - default constants for DATA_WIDTH, FIFO_DEPTH, RESULTS_PER_FRAME;
  - localparam PTR_W = log2(FIFO_DEPTH);
  - the counter widths (16, 32).
- One sub-module, drain_skid_fifo: synchronous FIFO with push/pop/full/empty/occupancy ports.
  - Pointer width PTR_W+1, using the wrap-bit full/empty scheme.
- The top level holds the credit logic, inflight register, framing counter and status counters.

Test Plan:
- Reset release, collector supplies 0x1..0x10 with rdy=1 and tready=1 → 16 words out in order, one per cycle from cycle 2 after the first ren; tlast only on 0x10; frame_count=1; word_count=16.
- tready held 0 for 10 cycles with rdy=1 → ren issues exactly 4 times then holds 0; tvalid=1 with tdata constant; overflow_err=0. Releasing tready drains 4 words, then reads resume.
- drain_en deasserted in the same cycle as an issued ren → no further ren; the in-flight word still appears on m_axis; no data lost or duplicated.
- Random tready (50%) and random rdy over 1000 words, RESULTS_PER_FRAME=16 → output sequence equals input sequence; tlast on every 16th word; frame_count=62; word_count=1000.
- reset asserted low while buffer holds 3 words and inflight=1 → all outputs 0 immediately, without waiting for a clock edge; after release the first word out is the next word read.
- RESULTS_PER_FRAME=1 build, 5 words → tlast high on all 5; frame_count=5.
